// File: rtl/seq_signed_multiplier_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM state encoding
// and the default operand width.
package seq_signed_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/seq_signed_multiplier_row.sv
// One partial-product row: acc +/- (mbit ? a_shifted : 0) as a ripple chain of
// full-adder cells with AND-gated addend bits.
module mult_row
    import seq_signed_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] a_shifted_i,
    input  logic               mbit_i,
    input  logic               sub_i,
    output logic [2*WIDTH-1:0] acc_next_o
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] addend;
    logic [PW-1:0] carry;

    // Subtraction is two's complement: invert the gated addend and inject carry-in 1.
    assign carry[0] = sub_i;

    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_cell
            assign addend[gi]     = (a_shifted_i[gi] & mbit_i) ^ sub_i;
            assign acc_next_o[gi] = acc_i[gi] ^ addend[gi] ^ carry[gi];
            if (gi < PW - 1) begin : g_carry
                assign carry[gi+1] = (acc_i[gi] & addend[gi])
                                   | (carry[gi] & (acc_i[gi] ^ addend[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/seq_signed_multiplier.sv
// Iterative two's-complement multiplier: one partial-product row per clock,
// start/busy/done handshake, registered product held until the next completion.
module seq_signed_multiplier
    import seq_signed_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    count_q;
    logic [PW-1:0]    product_q;
    logic             busy_q;
    logic             done_q;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    a_shifted;
    logic             row_bit;
    logic             last_row;
    logic [PW-1:0]    acc_d;

    assign a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign a_shifted = a_ext << count_q;
    assign row_bit   = b_q[count_q];
    // The sign row of a two's-complement multiplier carries negative weight.
    assign last_row  = (count_q == CW'(WIDTH - 1));

    mult_row #(
        .WIDTH(WIDTH)
    ) u_row (
        .acc_i       (acc_q),
        .a_shifted_i (a_shifted),
        .mbit_i      (row_bit),
        .sub_i       (last_row),
        .acc_next_o  (acc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    if (last_row) begin
                        product_q <= acc_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed bench for seq_signed_multiplier at WIDTH=3 and WIDTH=4.
module tb_seq_signed_multiplier;

    logic       clk = 1'b0;
    logic       reset;
    logic       start3, start4;
    logic [2:0] a3, b3;
    logic [3:0] a4, b4;
    logic [5:0] product3;
    logic [7:0] product4;
    logic       busy3, done3, busy4, done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_signed_multiplier #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3),
        .product(product3), .busy(busy3), .done(done3)
    );

    seq_signed_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .product(product4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single operation on the WIDTH=3 unit with latency, busy-length and pulse-width checks.
    task automatic op3(input logic [2:0] ai, input logic [2:0] bi, input logic [5:0] exp, input string tag);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a3 = ai; b3 = bi; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (done3 !== 1'b1 && cyc < 20) begin
            if (busy3 === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_busy_cycles"}, busy_cnt, 3);
        check({tag, "_product"}, product3, exp);
        $display("op3 %s a=%b b=%b product=%b latency=%0d", tag, ai, bi, product3, cyc);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done3, 1'b0);
    endtask

    task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        a4 = ai; b4 = bi; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_product"}, product4, exp);
        $display("op4 %s a=%b b=%b product=%b latency=%0d", tag, ai, bi, product4, cyc);
        @(negedge clk);
    endtask

    initial begin
        int dones;
        int cyc;
        int interval;
        logic signed [2:0] sa, sb;
        int p;
        logic [5:0] exp6;

        reset = 1'b1;
        start3 = 1'b0; start4 = 1'b0;
        a3 = '0; b3 = '0; a4 = '0; b4 = '0;
        #12;
        check("reset_product", product3, 6'd0);
        check("reset_busy", busy3, 1'b0);
        check("reset_done", done3, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        op3(3'd3, 3'b110, 6'b111010, "3x-2");
        op3(3'b100, 3'b100, 6'b010000, "-4x-4");
        op3(3'b100, 3'd3, 6'b110100, "-4x3");
        op3(3'd0, 3'b111, 6'b000000, "0x-1");

        // Start held into the first CALC cycle with new operands must not start a second op.
        @(negedge clk);
        a3 = 3'd2; b3 = 3'd3; start3 = 1'b1;
        @(negedge clk);
        a3 = 3'b111; b3 = 3'b111;
        @(negedge clk);
        start3 = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done3 === 1'b1) dones++;
            @(negedge clk);
        end
        check("ignored_start_dones", dones, 1);
        check("ignored_start_product", product3, 6'b000110);
        $display("ignored-start dones=%0d product=%b", dones, product3);

        // Reset in the second CALC cycle aborts with no done.
        @(negedge clk);
        a3 = 3'd3; b3 = 3'd3; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_product", product3, 6'd0);
        check("abort_busy", busy3, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done3 === 1'b1) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        $display("abort product=%b busy=%b dones=%0d", product3, busy3, dones);
        op3(3'd3, 3'd3, 6'b001001, "3x3");

        // Back-to-back sweep with start held high.
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd0; start3 = 1'b1;
        for (int k = 0; k < 64; k++) begin
            cyc = 0;
            while (done3 !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            interval = cyc + 1;
            sa = 3'(k >> 3);
            sb = 3'(k);
            p = int'(sa) * int'(sb);
            exp6 = 6'(p);
            check($sformatf("sweep_%0d_product", k), product3, exp6);
            if (k > 0) check($sformatf("sweep_%0d_interval", k), interval, 5);
            $display("sweep a=%0d b=%0d product=%b expected=%b interval=%0d", sa, sb, product3, exp6, interval);
            if (k < 63) begin
                a3 = 3'((k + 1) >> 3);
                b3 = 3'(k + 1);
            end else begin
                start3 = 1'b0;
            end
            @(negedge clk);
        end

        op4(4'b1000, 4'b1000, 8'b01000000, "w4_-8x-8");
        op4(4'd7, 4'b1000, 8'b11001000, "w4_7x-8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
